rpn_eval: RTL and testbench
===========================

Name: rpn_eval

Overview:
- Downstream stage of the prefix-to-RPN converter.
- Accepts one packed 19-token postfix (RPN) word and evaluates it with an internal operand stack, one token per cycle.
- Emits a signed result, or an error flag for malformed or undefined expressions.
- Feeds the result/check logic that follows the converter.

Parameters:
- N_TOK, 19, tokens per packed word
- TOK_W, 5, bits per token
- RES_W, 48, signed result and stack-entry width
- STK_D, 10, operand stack depth

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle pulse; in_rpn is valid
- in_rpn  in  N_TOK*TOK_W (95)  packed tokens; token 0 = bits [94:90], token 18 = bits [4:0]
- busy  out  1  high while a job is in flight
- out_valid  out  1  one-cycle result strobe
- out  out  RES_W  signed result; 0 when not valid or on error
- out_err  out  1  error flag, qualified by out_valid

Behaviour:
- Reset: synchronous, active-high. All outputs 0; state IDLE; stack and depth cleared. Reset mid-job discards the job; no out_valid for it.
- Token encoding:
  - bit4=0: operand, unsigned 0..15, zero-extended to RES_W.
  - bit4=1: operator; bits[1:0] select 0 add (16), 1 sub (17), 2 mul (18), 3 div (19). Bits[3:2] ignored.
- States:
  - IDLE: in_valid=1 latches in_rpn into a token shift register, clears stack/depth/err/token count, and moves to EVAL. in_valid while not in IDLE is ignored.
  - EVAL: processes exactly one token per cycle, token 0 first. The count runs 0..18; goes to FIN after token 18.
  - FIN: 1 cycle. Computes the final outcome, registers outputs, returns to IDLE.
- Latency:
  - in_valid at cycle 0, out_valid high in cycle 21 for exactly one cycle.
  - busy is high in cycles 1..20.
  - A new in_valid is accepted in cycle 21 (back-to-back throughput of 21 cycles).
- Operand token:
  - Push if depth < STK_D.
  - Otherwise set err (overflow).
- Operator token:
  - Needs depth >= 2, else set err (underflow).
  - b = top, a = next; pop both, push (a op b); depth decreases by 1.
- Arithmetic:
  - Two's complement, RES_W bits.
  - add/sub/mul wrap modulo 2^RES_W; no overflow error. Mul keeps the low RES_W bits of the product.
  - div: signed, truncates toward zero (-7/2 = -3). b==0 sets err. Most-negative / -1 wraps to most-negative.
- Sticky err: once set, the remaining tokens are still counted (latency unchanged) but the stack is not modified.
- FIN outcome:
  - err=0 and depth==1: out = stack[0], out_err = 0.
  - Otherwise: out = 0, out_err = 1.
- out and out_err are 0 in every cycle where out_valid=0.

Decomposition:
- Shared package prefix_pkg:
  - TOK_W, N_TOK
  - opcode enum (ADD=0, SUB=1, MUL=2, DIV=3)
  - token operator bit index (4)
  - state enum (IDLE, EVAL, FIN)
- One combinational sub-module, rpn_alu (a, b, op -> result, div_zero), isolates the divider for synthesis constraints.
- Stack, counters and FSM stay in rpn_eval.

Test Plan:
- Tokens 1,2,...,10 then nine 16 (peak depth 10) -> out_valid at cycle 21, out=55, out_err=0.
- Tokens 15,15,18 then eight pairs (15,18) -> out=576650390625 (15^10), out_err=0.
- Tokens 0,7,17,2,19 then seven pairs (0,16) -> out=-3 (truncation toward zero), out_err=0.
- Tokens 5,0,19 then eight pairs (0,16) -> out_err=1, out=0.
- Malformed inputs, each -> out_err=1, out=0, latency still 21:
  - all nineteen tokens =16 (underflow)
  - nineteen operands =1 (overflow at the 11th push)
- Handshake/reset:
  - second in_valid at cycle 5 is ignored (single out_valid at 21)
  - in_valid in cycle 21 is accepted (next out_valid at 42)
  - rst at cycle 10 -> busy=0 and no out_valid afterwards

Source files
------------

// File: rtl/prefix_pkg.sv
// Shared definitions for the prefix-to-RPN converter and its RPN evaluator.
// Holds token geometry, arithmetic widths, the operator encoding and the
// evaluator FSM state encoding.
package prefix_pkg;

    localparam int N_TOK   = 19;  // tokens per packed word
    localparam int TOK_W   = 5;   // bits per token
    localparam int RES_W   = 48;  // signed result / stack entry width
    localparam int STK_D   = 10;  // operand stack depth
    localparam int OP_BIT  = 4;   // token bit that marks an operator
    localparam int DEPTH_W = 4;   // holds 0..STK_D
    localparam int CNT_W   = 5;   // holds 0..N_TOK-1

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational RES_W-bit two's complement ALU for the RPN evaluator; kept
// separate so the divider can be given its own timing constraints.
// Ports: a (next-of-stack), b (top-of-stack), op (opcode) -> result, div_zero.
module rpn_alu
    import prefix_pkg::*;
(
    input  logic [RES_W-1:0] a,
    input  logic [RES_W-1:0] b,
    input  logic [1:0]       op,
    output logic [RES_W-1:0] result,
    output logic             div_zero
);

    localparam logic [RES_W-1:0] MOST_NEG = {1'b1, {(RES_W-1){1'b0}}};

    logic signed [RES_W-1:0] sa;
    logic signed [RES_W-1:0] sb;

    assign sa = $signed(a);
    assign sb = $signed(b);

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (opcode_e'(op))
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = a * b;  // low RES_W bits of the product
            OP_DIV: begin
                if (b == '0) begin
                    div_zero = 1'b1;
                end else if (a == MOST_NEG && (&b)) begin
                    // most-negative / -1 does not fit; it wraps to itself
                    result = a;
                end else begin
                    // signed divide truncates toward zero
                    result = sa / sb;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rpn_eval.sv
// Evaluates one packed 19-token RPN word, one token per cycle, on a 10-deep
// operand stack. Ports: clk, rst (sync, active-high), in_valid/in_rpn (job
// start), busy, out_valid/out/out_err (one-cycle result strobe, 21 cycles later).
module rpn_eval
    import prefix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_TOK*TOK_W-1:0] in_rpn,
    output logic                   busy,
    output logic                   out_valid,
    output logic [RES_W-1:0]       out,
    output logic                   out_err
);

    state_e                 state_q;
    state_e                 state_d;
    logic [N_TOK*TOK_W-1:0] tok_sr;
    logic [TOK_W-1:0]       tok;
    logic [RES_W-1:0]       stack [STK_D];
    logic [DEPTH_W-1:0]     depth;
    logic [CNT_W-1:0]       cnt;
    logic                   err;
    logic [DEPTH_W-1:0]     top_idx;
    logic [DEPTH_W-1:0]     nxt_idx;
    logic [RES_W-1:0]       alu_res;
    logic                   alu_div_zero;

    // Current token is always the head of the shift register.
    assign tok  = tok_sr[N_TOK*TOK_W-1 -: TOK_W];
    assign busy = (state_q != ST_IDLE);

    // Clamp the operand indices so shallow stacks never index out of range;
    // the operator path checks depth before using the ALU result.
    always_comb begin
        top_idx = '0;
        nxt_idx = '0;
        if (depth >= DEPTH_W'(1)) top_idx = depth - DEPTH_W'(1);
        if (depth >= DEPTH_W'(2)) nxt_idx = depth - DEPTH_W'(2);
    end

    rpn_alu u_alu (
        .a        (stack[nxt_idx]),
        .b        (stack[top_idx]),
        .op       (tok[1:0]),
        .result   (alu_res),
        .div_zero (alu_div_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EVAL;
            ST_EVAL: if (cnt == CNT_W'(N_TOK-1)) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_sr    <= '0;
            depth     <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
            for (int i = 0; i < STK_D; i++) stack[i] <= '0;
        end else begin
            // Outputs are strobes: zero unless FIN drives them this cycle.
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        tok_sr <= in_rpn;
                        depth  <= '0;
                        cnt    <= '0;
                        err    <= 1'b0;
                        for (int i = 0; i < STK_D; i++) stack[i] <= '0;
                    end
                end
                ST_EVAL: begin
                    tok_sr <= tok_sr << TOK_W;
                    cnt    <= cnt + CNT_W'(1);
                    // Once err is set the stack is frozen; tokens still count.
                    if (!err) begin
                        if (!tok[OP_BIT]) begin
                            if (depth < DEPTH_W'(STK_D)) begin
                                stack[depth] <= RES_W'(tok[3:0]);
                                depth        <= depth + DEPTH_W'(1);
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (depth < DEPTH_W'(2) || alu_div_zero) begin
                            err <= 1'b1;
                        end else begin
                            stack[nxt_idx] <= alu_res;
                            depth          <= depth - DEPTH_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    out_valid <= 1'b1;
                    if (!err && depth == DEPTH_W'(1)) out     <= stack[0];
                    else                              out_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_eval.sv
// Randomised + directed bench for rpn_eval with a queue-based scoreboard.
// Stimulus pushes expected {result, err, cycle}; a negedge monitor pops and
// compares on every out_valid and checks idle outputs stay zero otherwise.
module tb_rpn_eval;
    import prefix_pkg::*;

    localparam int W = N_TOK*TOK_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_rpn = '0;
    logic             busy;
    logic             out_valid;
    logic [RES_W-1:0] out;
    logic             out_err;

    rpn_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_rpn    (in_rpn),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0] res;
        bit               err;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tk[N_TOK];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every result strobe against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_value", {16'd0, out}, {16'd0, e.res});
                check("out_err", {63'd0, out_err}, {63'd0, e.err});
                check("out_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (out !== '0 || out_err !== 1'b0) begin
            check("idle_outputs_zero", {15'd0, out_err, out}, 64'd0);
        end
    end

    // Reference model: evaluate the RPN word with a plain queue stack.
    task automatic model(input logic [W-1:0] w, output logic [RES_W-1:0] r, output bit e);
        logic signed [RES_W-1:0] st[$];
        logic signed [RES_W-1:0] a, b, v;
        logic [TOK_W-1:0] t;
        e = 0;
        r = '0;
        for (int i = 0; i < N_TOK; i++) begin
            t = w[(N_TOK-1-i)*TOK_W +: TOK_W];
            if (e) continue;
            if (!t[4]) begin
                if (st.size() >= STK_D) e = 1;
                else st.push_back(RES_W'(t[3:0]));
            end else if (st.size() < 2) begin
                e = 1;
            end else begin
                b = st.pop_back();
                a = st.pop_back();
                v = '0;
                case (t[1:0])
                    2'd0: v = a + b;
                    2'd1: v = a - b;
                    2'd2: v = a * b;
                    default: begin
                        if (b == 0) e = 1;
                        else if (a == -(48'sd1 <<< 47) && b == -48'sd1) v = a;
                        else v = a / b;
                    end
                endcase
                st.push_back(v);
            end
        end
        if (!e && st.size() == 1) r = st[0];
        else e = 1;
        if (e) r = '0;
    endtask

    function automatic logic [W-1:0] pack_tk();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N_TOK; i++) w[(N_TOK-1-i)*TOK_W +: TOK_W] = tk[i][4:0];
        return w;
    endfunction

    // Well-formed generator: 10 operands, 9 operators, random ops/values.
    function automatic logic [W-1:0] gen_wf();
        int p = 0, d = 0;
        for (int i = 0; i < N_TOK; i++) begin
            if (p < STK_D && (d < 2 || $urandom_range(0, 1) == 1)) begin
                tk[i] = ($urandom_range(0, 3) == 0) ? 15 * $urandom_range(0, 1) : $urandom_range(0, 15);
                p++; d++;
            end else begin
                tk[i] = 16 + $urandom_range(0, 15);
                d--;
            end
        end
        return pack_tk();
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a job in the current cycle; expected strobe is 21 cycles later.
    task automatic send(input logic [W-1:0] w, input logic [RES_W-1:0] res, input bit err);
        exp_t e;
        e.res = res;
        e.err = err;
        e.cyc = cyc + 21;
        in_rpn   = w;
        in_valid = 1'b1;
        sb.push_back(e);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [W-1:0] w);
        logic [RES_W-1:0] r;
        bit e;
        model(w, r, e);
        send(w, r, e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        step(1);
    endtask

    initial begin
        int c0;
        logic [W-1:0] w;

        step(3);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out", {16'd0, out}, 64'd0);
        rst = 1'b0;
        step(2);

        // 1..10 then nine adds -> 55, with busy window checks
        for (int i = 0; i < 10; i++) tk[i] = i + 1;
        for (int i = 10; i < N_TOK; i++) tk[i] = 16;
        c0 = cyc;
        send(pack_tk(), 48'd55, 0);
        check("busy_first", {63'd0, busy}, 64'd1);
        step(c0 + 20 - cyc);
        check("busy_last", {63'd0, busy}, 64'd1);
        step(1);
        check("busy_done", {63'd0, busy}, 64'd0);
        drain();

        // 15^10 by repeated multiply
        tk[0] = 15; tk[1] = 15; tk[2] = 18;
        for (int i = 3; i < N_TOK; i += 2) begin tk[i] = 15; tk[i+1] = 18; end
        send(pack_tk(), 48'd576650390625, 0);
        drain();

        // (0-7)/2 = -3, truncation toward zero
        tk[0] = 0; tk[1] = 7; tk[2] = 17; tk[3] = 2; tk[4] = 19;
        for (int i = 5; i < N_TOK; i += 2) begin tk[i] = 0; tk[i+1] = 16; end
        send(pack_tk(), -48'sd3, 0);
        drain();

        // divide by zero
        tk[0] = 5; tk[1] = 0; tk[2] = 19;
        for (int i = 3; i < N_TOK; i += 2) begin tk[i] = 0; tk[i+1] = 16; end
        send(pack_tk(), '0, 1);
        drain();

        // underflow: all adds
        for (int i = 0; i < N_TOK; i++) tk[i] = 16;
        send(pack_tk(), '0, 1);
        drain();

        // overflow: nineteen pushes
        for (int i = 0; i < N_TOK; i++) tk[i] = 1;
        send(pack_tk(), '0, 1);
        drain();

        // second in_valid mid-job is ignored
        c0 = cyc;
        w = gen_wf();
        send_model(w);
        step(c0 + 5 - cyc);
        in_rpn = '1;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        drain();

        // back-to-back: accepted in the strobe cycle, next strobe 21 later
        c0 = cyc;
        send_model(gen_wf());
        step(c0 + 21 - cyc);
        send_model(gen_wf());
        drain();

        // reset mid-job discards the job
        c0 = cyc;
        send_model(gen_wf());
        step(c0 + 10 - cyc);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb.delete();
        check("reset_midjob_busy", {63'd0, busy}, 64'd0);
        step(30);

        // randomized jobs: mostly well-formed, some raw random words
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 3) == 0) w = W'({$urandom, $urandom, $urandom});
            else w = gen_wf();
            send_model(w);
            if ($urandom_range(0, 1) == 1) drain();
            else begin
                step(20);
                drain();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
